mem_port_arbiter: RTL and testbench

Arbitrates the core's three memory requesters onto one shared, single-outstanding memory port: instruction fetch read, data read and data write. Sits between the core and the memory/MMU-side bus. Serialises all requests captured in one core cycle and holds the pipeline with `MEM_WAIT` until every captured request has completed. Returns read results on the core's existing `*_RVALID` / `*_ROADDR` / `*_RDATA` inputs.

---
 rtl/mem_port_arbiter.sv | 233 +++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Serialises instruction fetch, data read and data write onto a single-outstanding
// memory port, holding the core with MEM_WAIT until the whole captured batch completes.
module mem_port_arbiter #(
    parameter int TIMEOUT = 256
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        INST_RDEN,
    input  logic [31:0] INST_RIADDR,
    output logic [31:0] INST_ROADDR,
    output logic        INST_RVALID,
    output logic [31:0] INST_RDATA,
    input  logic        DATA_RDEN,
    input  logic [31:0] DATA_RIADDR,
    output logic [31:0] DATA_ROADDR,
    output logic        DATA_RVALID,
    output logic [31:0] DATA_RDATA,
    input  logic        DATA_WREN,
    input  logic [31:0] DATA_WADDR,
    input  logic [31:0] DATA_WDATA,
    output logic        MEM_WAIT,
    output logic        BUS_REQ,
    output logic        BUS_WE,
    output logic [31:0] BUS_ADDR,
    output logic [31:0] BUS_WDATA,
    input  logic        BUS_ACK,
    input  logic [31:0] BUS_RDATA,
    output logic        BUS_ERR
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_XFER = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [2:0]    pend_q, pend_d;     // {W, DR, IR}
    logic [1:0]    rdm_q, rdm_d;       // reads captured in this batch {DR, IR}
    logic [31:0]   iaddr_q, iaddr_d, daddr_q, daddr_d;
    logic [31:0]   waddr_q, waddr_d, wdata_q, wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [31:0]   ires_q, ires_d, dres_q, dres_d;
    logic          breq_q, breq_d, bwe_q, bwe_d, berr_q, berr_d;
    logic [31:0]   baddr_q, baddr_d, bwdata_q, bwdata_d;
    logic          iv_q, iv_d, dv_q, dv_d;
    logic [31:0]   iro_q, iro_d, ird_q, ird_d, dro_q, dro_d, drd_q, drd_d;

    logic          any_req;
    logic          load;
    logic [2:0]    nxt_mask;
    logic [31:0]   src_i, src_d, src_w, src_wd, rres;

    assign any_req  = DATA_WREN | DATA_RDEN | INST_RDEN;
    assign MEM_WAIT = (state_q == S_XFER) || ((state_q == S_IDLE) && any_req);

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        rdm_d    = rdm_q;
        iaddr_d  = iaddr_q;
        daddr_d  = daddr_q;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        ires_d   = ires_q;
        dres_d   = dres_q;
        breq_d   = breq_q;
        bwe_d    = bwe_q;
        baddr_d  = baddr_q;
        bwdata_d = bwdata_q;
        berr_d   = 1'b0;
        iv_d     = 1'b0;
        dv_d     = 1'b0;
        iro_d    = iro_q;
        ird_d    = ird_q;
        dro_d    = dro_q;
        drd_d    = drd_q;
        load     = 1'b0;
        nxt_mask = pend_q;
        src_i    = iaddr_q;
        src_d    = daddr_q;
        src_w    = waddr_q;
        src_wd   = wdata_q;
        rres     = '0;

        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    pend_d   = {DATA_WREN, DATA_RDEN, INST_RDEN};
                    rdm_d    = {DATA_RDEN, INST_RDEN};
                    iaddr_d  = INST_RIADDR;
                    daddr_d  = DATA_RIADDR;
                    waddr_d  = DATA_WADDR;
                    wdata_d  = DATA_WDATA;
                    err_d    = 1'b0;
                    // First transfer is driven straight from the inputs so BUS_REQ rises next cycle
                    load     = 1'b1;
                    nxt_mask = pend_d;
                    src_i    = INST_RIADDR;
                    src_d    = DATA_RIADDR;
                    src_w    = DATA_WADDR;
                    src_wd   = DATA_WDATA;
                    state_d  = S_XFER;
                end
            end
            S_XFER: begin
                if (!breq_q) begin
                    state_d = S_IDLE;
                end else if (BUS_ACK || (cnt_q == CNT_LAST)) begin
                    // An ack on the last allowed cycle still counts as a normal completion
                    rres = BUS_ACK ? BUS_RDATA : 32'h0;
                    if (!BUS_ACK) err_d = 1'b1;
                    if (pend_q[2]) begin
                        pend_d[2] = 1'b0;
                    end else if (pend_q[1]) begin
                        pend_d[1] = 1'b0;
                        dres_d    = rres;
                    end else begin
                        pend_d[0] = 1'b0;
                        ires_d    = rres;
                    end
                    if (pend_d != 3'b000) begin
                        load     = 1'b1;
                        nxt_mask = pend_d;
                    end else begin
                        breq_d  = 1'b0;
                        bwe_d   = 1'b0;
                        state_d = S_DONE;
                        iv_d    = rdm_q[0];
                        dv_d    = rdm_q[1];
                        if (rdm_q[0]) begin
                            iro_d = iaddr_q;
                            ird_d = ires_d;
                        end
                        if (rdm_q[1]) begin
                            dro_d = daddr_q;
                            drd_d = dres_d;
                        end
                        berr_d = err_d;
                        err_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (load) begin
            breq_d = 1'b1;
            cnt_d  = '0;
            if (nxt_mask[2]) begin
                bwe_d    = 1'b1;
                baddr_d  = src_w;
                bwdata_d = src_wd;
            end else if (nxt_mask[1]) begin
                bwe_d   = 1'b0;
                baddr_d = src_d;
            end else begin
                bwe_d   = 1'b0;
                baddr_d = src_i;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= S_IDLE;
            pend_q   <= '0;
            rdm_q    <= '0;
            iaddr_q  <= '0;
            daddr_q  <= '0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            ires_q   <= '0;
            dres_q   <= '0;
            breq_q   <= 1'b0;
            bwe_q    <= 1'b0;
            baddr_q  <= '0;
            bwdata_q <= '0;
            berr_q   <= 1'b0;
            iv_q     <= 1'b0;
            dv_q     <= 1'b0;
            iro_q    <= '0;
            ird_q    <= '0;
            dro_q    <= '0;
            drd_q    <= '0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            rdm_q    <= rdm_d;
            iaddr_q  <= iaddr_d;
            daddr_q  <= daddr_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            ires_q   <= ires_d;
            dres_q   <= dres_d;
            breq_q   <= breq_d;
            bwe_q    <= bwe_d;
            baddr_q  <= baddr_d;
            bwdata_q <= bwdata_d;
            berr_q   <= berr_d;
            iv_q     <= iv_d;
            dv_q     <= dv_d;
            iro_q    <= iro_d;
            ird_q    <= ird_d;
            dro_q    <= dro_d;
            drd_q    <= drd_d;
        end
    end

    assign BUS_REQ     = breq_q;
    assign BUS_WE      = bwe_q;
    assign BUS_ADDR    = baddr_q;
    assign BUS_WDATA   = bwdata_q;
    assign BUS_ERR     = berr_q;
    assign INST_RVALID = iv_q;
    assign INST_ROADDR = iro_q;
    assign INST_RDATA  = ird_q;
    assign DATA_RVALID = dv_q;
    assign DATA_ROADDR = dro_q;
    assign DATA_RDATA  = drd_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: bus transfers and read returns are queued
// as stimulus is issued and retired when the DUT presents them.
module tb_mem_port_arbiter;
    localparam int TO = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        INST_RDEN = 1'b0, DATA_RDEN = 1'b0, DATA_WREN = 1'b0;
    logic [31:0] INST_RIADDR = '0, DATA_RIADDR = '0, DATA_WADDR = '0, DATA_WDATA = '0;
    logic [31:0] INST_ROADDR, INST_RDATA, DATA_ROADDR, DATA_RDATA;
    logic        INST_RVALID, DATA_RVALID, MEM_WAIT;
    logic        BUS_REQ, BUS_WE, BUS_ERR;
    logic [31:0] BUS_ADDR, BUS_WDATA;
    logic        BUS_ACK = 1'b0;
    logic [31:0] BUS_RDATA = '0;

    mem_port_arbiter #(.TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST),
        .INST_RDEN(INST_RDEN), .INST_RIADDR(INST_RIADDR), .INST_ROADDR(INST_ROADDR),
        .INST_RVALID(INST_RVALID), .INST_RDATA(INST_RDATA),
        .DATA_RDEN(DATA_RDEN), .DATA_RIADDR(DATA_RIADDR), .DATA_ROADDR(DATA_ROADDR),
        .DATA_RVALID(DATA_RVALID), .DATA_RDATA(DATA_RDATA),
        .DATA_WREN(DATA_WREN), .DATA_WADDR(DATA_WADDR), .DATA_WDATA(DATA_WDATA),
        .MEM_WAIT(MEM_WAIT), .BUS_REQ(BUS_REQ), .BUS_WE(BUS_WE), .BUS_ADDR(BUS_ADDR),
        .BUS_WDATA(BUS_WDATA), .BUS_ACK(BUS_ACK), .BUS_RDATA(BUS_RDATA), .BUS_ERR(BUS_ERR)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } bus_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; } rd_t;

    bus_t bus_q[$];
    rd_t  iexp_q[$];
    rd_t  dexp_q[$];
    logic [31:0] mem     [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    int ack_dly = 0;
    bit no_ack = 1'b0;
    bit stray = 1'b0;
    int req_cnt = 0;
    int req_cycles = 0;

    function automatic logic [31:0] bus_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : (a ^ 32'hA5A5_0000);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : (a ^ 32'hA5A5_0000);
    endfunction

    // memory-side responder: checks every requested cycle against the expected transfer
    always @(negedge CLK) begin
        bus_t e;
        BUS_ACK   = stray;
        BUS_RDATA = stray ? 32'hBAD0_0BAD : 32'h0;
        if (BUS_REQ === 1'b1) begin
            req_cycles++;
            if (bus_q.size() == 0) begin
                chk("bus_spurious", 32'(BUS_REQ), 32'h0);
            end else begin
                e = bus_q[0];
                chk("bus_we", 32'(BUS_WE), 32'(e.we));
                chk("bus_addr", BUS_ADDR, e.addr);
                if (e.we) chk("bus_wdata", BUS_WDATA, e.wdata);
                if (!no_ack && req_cnt == ack_dly) begin
                    BUS_ACK = 1'b1;
                    if (e.we) mem[e.addr] = BUS_WDATA;
                    else BUS_RDATA = bus_rd(BUS_ADDR);
                    void'(bus_q.pop_front());
                    req_cnt = 0;
                end else if (no_ack && req_cnt == TO - 1) begin
                    void'(bus_q.pop_front());
                    req_cnt = 0;
                end else begin
                    req_cnt++;
                end
            end
        end else begin
            req_cnt = 0;
        end
    end

    always @(negedge CLK) begin
        rd_t r;
        if (RST) begin
            if (INST_RVALID === 1'b1) begin
                if (iexp_q.size() == 0) chk("inst_rvalid_spurious", 32'(INST_RVALID), 32'h0);
                else begin
                    r = iexp_q.pop_front();
                    chk("inst_roaddr", INST_ROADDR, r.addr);
                    chk("inst_rdata", INST_RDATA, r.data);
                end
            end
            if (DATA_RVALID === 1'b1) begin
                if (dexp_q.size() == 0) chk("data_rvalid_spurious", 32'(DATA_RVALID), 32'h0);
                else begin
                    r = dexp_q.pop_front();
                    chk("data_roaddr", DATA_ROADDR, r.addr);
                    chk("data_rdata", DATA_RDATA, r.data);
                end
            end
        end
    end

    task automatic push_batch(input bit w, input logic [31:0] wa, input logic [31:0] wd,
                              input bit dr, input logic [31:0] da,
                              input bit ir, input logic [31:0] ia);
        bus_t b;
        rd_t  r;
        if (w) begin
            b.we = 1'b1; b.addr = wa; b.wdata = wd;
            bus_q.push_back(b);
            ref_mem[wa] = wd;
        end
        if (dr) begin
            b.we = 1'b0; b.addr = da; b.wdata = '0;
            bus_q.push_back(b);
            r.addr = da; r.data = no_ack ? 32'h0 : ref_rd(da);
            dexp_q.push_back(r);
        end
        if (ir) begin
            b.we = 1'b0; b.addr = ia; b.wdata = '0;
            bus_q.push_back(b);
            r.addr = ia; r.data = no_ack ? 32'h0 : ref_rd(ia);
            iexp_q.push_back(r);
        end
        @(negedge CLK);
        req_cycles  = 0;
        DATA_WREN   = w;  DATA_WADDR = wa; DATA_WDATA = wd;
        DATA_RDEN   = dr; DATA_RIADDR = da;
        INST_RDEN   = ir; INST_RIADDR = ia;
    endtask

    task automatic drop_inputs();
        DATA_WREN = 1'b0; DATA_RDEN = 1'b0; INST_RDEN = 1'b0;
    endtask

    task automatic batch(input bit w, input logic [31:0] wa, input logic [31:0] wd,
                         input bit dr, input logic [31:0] da,
                         input bit ir, input logic [31:0] ia,
                         input int exp_mw, input int exp_req, input bit exp_err);
        int cnt;
        push_batch(w, wa, wd, dr, da, ir, ia);
        #1;
        cnt = 0;
        while (MEM_WAIT === 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge CLK);
            #1;
        end
        chk("mem_wait_len", 32'(cnt), 32'(exp_mw));
        chk("req_cycles", 32'(req_cycles), 32'(exp_req));
        chk("bus_err_done", 32'(BUS_ERR), 32'(exp_err));
        drop_inputs();
        @(negedge CLK);
        #1;
        chk("bus_err_after", 32'(BUS_ERR), 32'h0);
        chk("reads_outstanding", 32'(iexp_q.size() + dexp_q.size()), 32'h0);
        chk("bus_outstanding", 32'(bus_q.size()), 32'h0);
        chk("mem_wait_idle", 32'(MEM_WAIT), 32'h0);
    endtask

    task automatic outputs_zero(input string tag);
        chk({tag, "_req"},    32'(BUS_REQ), 32'h0);
        chk({tag, "_we"},     32'(BUS_WE), 32'h0);
        chk({tag, "_addr"},   BUS_ADDR, 32'h0);
        chk({tag, "_wdata"},  BUS_WDATA, 32'h0);
        chk({tag, "_err"},    32'(BUS_ERR), 32'h0);
        chk({tag, "_ivalid"}, 32'(INST_RVALID), 32'h0);
        chk({tag, "_iaddr"},  INST_ROADDR, 32'h0);
        chk({tag, "_idata"},  INST_RDATA, 32'h0);
        chk({tag, "_dvalid"}, 32'(DATA_RVALID), 32'h0);
        chk({tag, "_daddr"},  DATA_ROADDR, 32'h0);
        chk({tag, "_ddata"},  DATA_RDATA, 32'h0);
        chk({tag, "_wait"},   32'(MEM_WAIT), 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        mem[32'h2000_0000]     = 32'h0000_0013;
        ref_mem[32'h2000_0000] = 32'h0000_0013;

        repeat (3) @(negedge CLK);
        #1;
        outputs_zero("rst");
        INST_RDEN = 1'b1;
        #1;
        chk("rst_wait_with_req", 32'(MEM_WAIT), 32'h1);
        INST_RDEN = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);

        // single fetch, immediate ack
        batch(0, 0, 0, 0, 0, 1, 32'h2000_0000, 2, 1, 0);

        // write/read/fetch in one cycle: write first, read sees the new data
        batch(1, 32'h100, 32'hDEAD_BEEF, 1, 32'h100, 1, 32'h2000_0004, 4, 3, 0);

        // read acked 3 cycles late
        ack_dly = 3;
        batch(0, 0, 0, 1, 32'h300, 0, 0, 5, 4, 0);
        ack_dly = 0;

        // two reads, both with an ack on the last allowed cycle
        ack_dly = TO - 1;
        batch(0, 0, 0, 1, 32'h340, 1, 32'h2000_0040, 9, 8, 0);
        ack_dly = 0;

        // timeout on a data read, then a clean batch
        no_ack = 1'b1;
        batch(0, 0, 0, 1, 32'h400, 0, 0, 1 + TO, TO, 1);
        no_ack = 1'b0;
        batch(0, 0, 0, 1, 32'h400, 0, 0, 2, 1, 0);

        // write then read of a different address
        batch(1, 32'h500, 32'h1234_5678, 1, 32'h504, 0, 0, 3, 2, 0);

        // stray ack while idle
        @(negedge CLK);
        stray = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            #1;
            chk("stray_wait", 32'(MEM_WAIT), 32'h0);
            chk("stray_req", 32'(BUS_REQ), 32'h0);
        end
        stray = 1'b0;

        // reset during the second transfer of a three-request batch
        ack_dly = 2;
        push_batch(1, 32'h600, 32'hCAFE_F00D, 1, 32'h604, 1, 32'h2000_0100);
        cnt = 0;
        while (bus_q.size() > 2 && cnt < 50) begin
            @(negedge CLK);
            #1;
            cnt++;
        end
        chk("first_xfer_done", 32'(bus_q.size()), 32'h2);
        @(negedge CLK);
        #2;
        chk("mid_second_req", 32'(BUS_REQ), 32'h1);
        RST = 1'b0;
        drop_inputs();
        #1;
        outputs_zero("abort");
        bus_q.delete();
        iexp_q.delete();
        dexp_q.delete();
        ack_dly = 0;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        stray = 1'b1;
        repeat (2) begin
            @(negedge CLK);
            #1;
            chk("post_rst_wait", 32'(MEM_WAIT), 32'h0);
            chk("post_rst_ivalid", 32'(INST_RVALID), 32'h0);
            chk("post_rst_dvalid", 32'(DATA_RVALID), 32'h0);
        end
        stray = 1'b0;
        batch(0, 0, 0, 0, 0, 1, 32'h2000_0008, 2, 1, 0);
        batch(0, 0, 0, 1, 32'h600, 0, 0, 2, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
